// File: rtl/dso_pkg.sv
// Shared types and encodings for the triggered sample-capture engine.
package dso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } dso_state_e;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_STOP   = 2'd3;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  localparam int DSO_W = 12;

endpackage

// File: rtl/dso_trigger.sv
// Edge detector on the stream of accepted samples; hit is combinational so the
// capture FSM can act on the same clock edge that writes the sample.
module dso_trigger
  import dso_pkg::*;
#(
  parameter int W = DSO_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         acc,
  input  logic [W-1:0] smp,
  input  logic [W-1:0] level,
  input  logic         slope,
  output logic         hit
);

  logic [W-1:0] prev_q;
  logic         prev_vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (clear) begin
      prev_vld_q <= 1'b0;
    end else if (acc) begin
      prev_q     <= smp;
      prev_vld_q <= 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    if (acc && prev_vld_q) begin
      if (slope == SLOPE_RISE) hit = (prev_q < level) && (smp >= level);
      else                     hit = (prev_q > level) && (smp <= level);
    end
  end

endmodule

// File: rtl/dso_capture.sv
// Triggered capture of one decimated ADC channel into a circular frame buffer,
// read back by screen column relative to the oldest stored sample.
//   state | meaning
//   IDLE  | after reset; waits for arm in single mode
//   PRE   | collecting pretrigger history
//   WAIT  | circular capture while looking for the trigger edge
//   POST  | filling the rest of the frame after the trigger
//   DONE  | frame held for the renderer, no writes
module dso_capture
  import dso_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int W       = DSO_W,
  parameter int DEPTH   = 640,
  parameter int AUTO_TO = 4096,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     smp_valid,
  input  logic [NCH*W-1:0]         smp_data,
  input  logic [$clog2(NCH)-1:0]   ch_sel,
  input  logic [W-1:0]             trig_level,
  input  logic                     trig_slope,
  input  logic [1:0]               mode,
  input  logic [7:0]               decim,
  input  logic [AW-1:0]            pretrig,
  input  logic                     arm,
  input  logic                     frame_ack,
  input  logic [AW-1:0]            rd_addr,
  output logic [W-1:0]             rd_data,
  output logic                     frame_ready,
  output logic                     triggered,
  output logic [2:0]               state
);

  localparam int CMAX = (DEPTH > AUTO_TO) ? DEPTH : AUTO_TO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] AUTO_L  = CW'(AUTO_TO);

  dso_state_e st_q, st_d;
  logic [1:0]             mode_q;
  logic [$clog2(NCH)-1:0] ch_q;
  logic [W-1:0]           level_q;
  logic                   slope_q;
  logic [7:0]             decim_q, dcnt_q;
  logic [AW-1:0]          pre_q, wp_q, start_q;
  logic [CW-1:0]          cnt_q, cnt_d, post_n;
  logic                   ready_q, trig_q;

  logic          stop, run, acc, hit, we, set_start, trig_d, enter_pre;
  logic [W-1:0]  cur;
  logic [AW-1:0] pre_clamp, start_nx, phys;
  logic [AW:0]   wp_x, pre_x, rsum;

  logic [W-1:0] mem [DEPTH];

  assign stop      = (mode == MODE_STOP);
  assign run       = (st_q inside {ST_PRE, ST_WAIT, ST_POST}) && !stop;
  assign acc       = run && smp_valid && (dcnt_q == 8'd0);
  assign cur       = smp_data[ch_q*W +: W];
  assign pre_clamp = ({1'b0, pretrig} >= DEPTH_L) ? AW'(DEPTH - 1) : pretrig;
  assign post_n    = CW'(DEPTH - 1) - CW'(pre_q);

  // Frame start is pretrig samples behind the trigger write, modulo DEPTH.
  assign wp_x     = {1'b0, wp_q};
  assign pre_x    = {1'b0, pre_q};
  assign start_nx = (wp_x >= pre_x) ? AW'(wp_x - pre_x) : AW'(wp_x + DEPTH_L - pre_x);

  dso_trigger #(.W(W)) u_trig (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (enter_pre),
    .acc     (acc),
    .smp     (cur),
    .level   (level_q),
    .slope   (slope_q),
    .hit     (hit)
  );

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    we        = 1'b0;
    set_start = 1'b0;
    trig_d    = 1'b0;
    enter_pre = 1'b0;
    if (!stop) begin
      unique case (st_q)
        ST_IDLE: enter_pre = (mode != MODE_SINGLE) || arm;
        ST_PRE: begin
          if (cnt_q == '0) begin
            st_d  = ST_WAIT;
            cnt_d = AUTO_L;
          end else if (acc) begin
            we = 1'b1;
            if (cnt_q == CW'(1)) begin
              st_d  = ST_WAIT;
              cnt_d = AUTO_L;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (acc) begin
            we = 1'b1;
            if (hit || (mode_q == MODE_AUTO && cnt_q == CW'(1))) begin
              set_start = 1'b1;
              trig_d    = hit;
              cnt_d     = post_n;
              st_d      = (post_n == '0) ? ST_DONE : ST_POST;
            end else if (mode_q == MODE_AUTO) begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        ST_POST: begin
          if (acc) begin
            we = 1'b1;
            if (cnt_q == CW'(1)) st_d = ST_DONE;
            else                 cnt_d = cnt_q - CW'(1);
          end
        end
        ST_DONE: enter_pre = (mode == MODE_SINGLE) ? arm : frame_ack;
        default: st_d = ST_IDLE;
      endcase
    end
    if (enter_pre) begin
      st_d  = ST_PRE;
      cnt_d = CW'(pre_clamp);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_AUTO;
      ch_q    <= '0;
      level_q <= '0;
      slope_q <= SLOPE_RISE;
      decim_q <= '0;
      pre_q   <= '0;
      dcnt_q  <= '0;
      wp_q    <= '0;
      start_q <= '0;
      ready_q <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ready_q <= (st_d == ST_DONE);
      trig_q  <= trig_d;
      if (enter_pre) begin
        mode_q  <= mode;
        ch_q    <= ch_sel;
        level_q <= trig_level;
        slope_q <= trig_slope;
        decim_q <= decim;
        pre_q   <= pre_clamp;
        dcnt_q  <= '0;
      end else if (run && smp_valid) begin
        dcnt_q <= (dcnt_q == 8'd0) ? decim_q : dcnt_q - 8'd1;
      end
      if (we) wp_q <= (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);
      if (set_start) start_q <= start_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wp_q] <= cur;
  end

  assign rsum = {1'b0, start_q} + {1'b0, rd_addr};
  assign phys = (rsum >= DEPTH_L) ? AW'(rsum - DEPTH_L) : rsum[AW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        rd_data <= '0;
    else if ({1'b0, rd_addr} >= DEPTH_L) rd_data <= '0;
    else                                 rd_data <= mem[phys];
  end

  assign frame_ready = ready_q;
  assign triggered   = trig_q;
  assign state       = st_q;

endmodule
